// File: rtl/kernel_transform_engine.sv
// kernel_transform_engine: streaming Winograd filter transform U' = G' g G'^T.
// Per-kernel choice of F(4,3) (6x6, gain 576) or F(2,3) (4x4, gain 4).
module kernel_transform_engine #(
    parameter int DATA_W = 16,
    parameter int OUT_W = DATA_W + 10,
    parameter int NUM_CH = 64,
    localparam int CH_W = ($clog2(NUM_CH) > 0) ? $clog2(NUM_CH) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  sync_clr,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_mode,
    input  logic signed [2:0][2:0][DATA_W-1:0]    kernel_in,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [5:0][5:0][OUT_W-1:0]     kernel_out,
    output logic                                  out_mode,
    output logic        [CH_W-1:0]                out_ch,
    output logic                                  out_last,
    output logic                                  busy
);

    if (OUT_W < DATA_W + 10) begin : g_out_w_chk
        $error("kernel_transform_engine: OUT_W must be >= DATA_W+10");
    end

    if (NUM_CH < 1) begin : g_num_ch_chk
        $error("kernel_transform_engine: NUM_CH must be >= 1");
    end

    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

    // One 1-D transform G' a of a 3-vector; both passes reuse it.
    // F(4,3) rows: [6,0,0] [-4,-4,-4] [-4,4,-4] [1,2,4] [1,-2,4] [0,0,24]
    // F(2,3) rows: [2,0,0] [1,1,1] [1,-1,1] [0,0,2], entries 4..5 zero.
    function automatic logic [5:0][OUT_W-1:0] xform(
        input logic                    m,
        input logic signed [OUT_W-1:0] a0,
        input logic signed [OUT_W-1:0] a1,
        input logic signed [OUT_W-1:0] a2
    );
        logic signed [OUT_W-1:0] s;
        logic signed [OUT_W-1:0] d;
        logic signed [OUT_W-1:0] e;
        logic signed [OUT_W-1:0] f;
        xform = '0;
        s = a0 + a1 + a2;
        d = a0 - a1 + a2;
        e = a0 + (a2 <<< 2);
        f = a1 <<< 1;
        unique case (1'b1)
            !m: begin
                xform[0] = (a0 <<< 2) + (a0 <<< 1);
                xform[1] = -(s <<< 2);
                xform[2] = -(d <<< 2);
                xform[3] = e + f;
                xform[4] = e - f;
                xform[5] = (a2 <<< 4) + (a2 <<< 3);
            end
            m: begin
                xform[0] = a0 <<< 1;
                xform[1] = s;
                xform[2] = d;
                xform[3] = a2 <<< 1;
            end
        endcase
    endfunction

    function automatic logic signed [OUT_W-1:0] sx(
        input logic [DATA_W-1:0] v
    );
        return OUT_W'($signed(v));
    endfunction

    logic                           t_vld;
    logic [5:0][2:0][OUT_W-1:0]     t_q;
    logic                           t_mode;
    logic [CH_W-1:0]                t_ch;
    logic [CH_W-1:0]                ch_q;
    logic                           u_adv;
    logic                           accept;
    logic [5:0][2:0][OUT_W-1:0]     t_d;
    logic [5:0][OUT_W-1:0]          col_v;
    logic [5:0][5:0][OUT_W-1:0]     u_d;

    assign u_adv    = !out_valid || out_ready;
    assign in_ready = rst_n && !sync_clr && (!t_vld || u_adv);
    assign accept   = in_valid && in_ready;
    assign busy     = t_vld || out_valid;

    // Column pass: T = G' g, each column of g transformed independently.
    always_comb begin
        t_d   = '0;
        col_v = '0;
        for (int c = 0; c < 3; c++) begin
            col_v = xform(in_mode,
                          sx(kernel_in[0][c]),
                          sx(kernel_in[1][c]),
                          sx(kernel_in[2][c]));
            for (int r = 0; r < 6; r++) begin
                t_d[r][c] = col_v[r];
            end
        end
    end

    // Row pass: U' = T G'^T, each row of T transformed independently.
    always_comb begin
        u_d = '0;
        for (int r = 0; r < 6; r++) begin
            u_d[r] = xform(t_mode,
                           $signed(t_q[r][0]),
                           $signed(t_q[r][1]),
                           $signed(t_q[r][2]));
        end
    end

    // Channel counter: tags each accepted kernel, wraps at NUM_CH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else if (sync_clr) begin
            ch_q <= '0;
        end else if (accept) begin
            ch_q <= (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
        end
    end

    // Stage 1: capture T with its mode and channel; empties when stage 2 takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_vld  <= 1'b0;
            t_q    <= '0;
            t_mode <= 1'b0;
            t_ch   <= '0;
        end else if (sync_clr) begin
            t_vld <= 1'b0;
        end else if (accept) begin
            t_vld  <= 1'b1;
            t_q    <= t_d;
            t_mode <= in_mode;
            t_ch   <= ch_q;
        end else if (u_adv) begin
            t_vld <= 1'b0;
        end
    end

    // Stage 2: output register; holds its kernel until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            kernel_out <= '0;
            out_mode   <= 1'b0;
            out_ch     <= '0;
            out_last   <= 1'b0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
        end else if (t_vld && u_adv) begin
            out_valid  <= 1'b1;
            kernel_out <= u_d;
            out_mode   <= t_mode;
            out_ch     <= t_ch;
            out_last   <= (t_ch == CH_MAX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kernel_transform_engine.sv
// tb_kernel_transform_engine: directed + random checks of the Winograd
// filter transform against a plain matrix-product reference model.
module tb_kernel_transform_engine;

    localparam int DATA_W = 16;
    localparam int OUT_W  = DATA_W + 10;
    localparam int NUM_CH = 64;
    localparam int CH_W   = 6;

    typedef logic [2:0][2:0][DATA_W-1:0] kern_t;
    typedef logic [5:0][5:0][OUT_W-1:0]  uout_t;

    typedef struct {
        uout_t u;
        logic  m;
        int    ch;
        int    acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sync_clr;
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    kern_t           kernel_in;
    logic            out_valid;
    logic            out_ready;
    uout_t           kernel_out;
    logic            out_mode;
    logic [CH_W-1:0] out_ch;
    logic            out_last;
    logic            busy;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    model_ch = 0;
    int    n_acc    = 0;
    int    seen_last = 0;
    exp_t  sbq[$];
    uout_t last_out = '0;
    int    last_ch  = -1;

    always #5 clk = ~clk;

    kernel_transform_engine #(
        .DATA_W(DATA_W),
        .OUT_W (OUT_W),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync_clr  (sync_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .kernel_in (kernel_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .kernel_out(kernel_out),
        .out_mode  (out_mode),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: U' = G' g G'^T as an explicit triple sum over integers.
    function automatic uout_t golden(input kern_t g, input logic m);
        int     g43[18] = '{6, 0, 0, -4, -4, -4, -4, 4, -4,
                            1, 2, 4, 1, -2, 4, 0, 0, 24};
        int     g23[18] = '{2, 0, 0, 1, 1, 1, 1, -1, 1,
                            0, 0, 2, 0, 0, 0, 0, 0, 0};
        longint gm[6][3];
        longint u;
        golden = '0;
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 3; k++)
                gm[r][k] = m ? g23[r*3+k] : g43[r*3+k];
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                u = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        u += gm[r][i] * longint'($signed(g[i][j])) * gm[c][j];
                golden[r][c] = OUT_W'(u);
            end
        end
    endfunction

    function automatic kern_t rand_kern();
        kern_t k;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                case ($urandom_range(0, 7))
                    0:       k[r][c] = 16'h8000;
                    1:       k[r][c] = 16'h7fff;
                    default: k[r][c] = DATA_W'($urandom);
                endcase
            end
        end
        return k;
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, score, advance.
    task automatic step(input logic iv, input logic m, input kern_t g,
                        input logic ordy, input logic clr);
        exp_t e;
        logic exp_ov;
        logic exp_rdy;
        in_valid  = iv;
        in_mode   = m;
        kernel_in = g;
        out_ready = ordy;
        sync_clr  = clr;
        #1;
        exp_ov  = (sbq.size() > 0) && (sbq[0].acc + 2 <= cyc);
        exp_rdy = !clr && (sbq.size() < 2 || ordy);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_rdy);
        chk("busy", busy, sbq.size() > 0);
        if (exp_ov && ordy) begin
            e = sbq.pop_front();
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++)
                    chk($sformatf("u[%0d][%0d] ch%0d", r, c, e.ch),
                        $signed(kernel_out[r][c]), $signed(e.u[r][c]));
            chk("out_mode", out_mode, e.m);
            chk("out_ch", out_ch, e.ch);
            chk("out_last", out_last, e.ch == NUM_CH - 1);
            if (out_last === 1'b1) seen_last++;
            last_out = kernel_out;
            last_ch  = int'(out_ch);
        end
        if (iv && exp_rdy) begin
            e.u   = golden(g, m);
            e.m   = m;
            e.ch  = model_ch;
            e.acc = cyc;
            sbq.push_back(e);
            model_ch = (model_ch + 1) % NUM_CH;
            n_acc++;
        end
        if (clr) begin
            sbq.delete();
            model_ch = 0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        kern_t k;
        rst_n     = 1'b0;
        sync_clr  = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        kernel_in = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_mode", out_mode, 0);
        chk("rst_kernel_out_zero", kernel_out == '0, 1);
        rst_n = 1'b1;

        // F(4,3) impulse at g[0][0]
        k = '0;
        k[0][0] = 16'd1;
        step(1, 0, k, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("f43_u00", $signed(last_out[0][0]), 36);
        chk("f43_u01", $signed(last_out[0][1]), -24);
        chk("f43_u11", $signed(last_out[1][1]), 16);
        chk("f43_u33", $signed(last_out[3][3]), 1);
        chk("f43_u05", $signed(last_out[0][5]), 0);
        chk("f43_u50", $signed(last_out[5][0]), 0);

        // F(2,3) impulse at g[1][1]
        k = '0;
        k[1][1] = 16'd1;
        step(1, 1, k, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("f23_u11", $signed(last_out[1][1]), 1);
        chk("f23_u12", $signed(last_out[1][2]), -1);
        chk("f23_u22", $signed(last_out[2][2]), 1);
        chk("f23_row0_zero", last_out[0] == '0, 1);
        chk("f23_u14", $signed(last_out[1][4]), 0);
        chk("f23_u41", $signed(last_out[4][1]), 0);

        // F(4,3) full-scale negative kernel
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                k[r][c] = 16'h8000;
        step(1, 0, k, 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("min_u55", $signed(last_out[5][5]), -18874368);
        chk("min_u00", $signed(last_out[0][0]), -1179648);

        // Back-to-back kernels with alternating mode and no backpressure
        for (int i = 0; i < 10; i++)
            step(1, i[0], rand_kern(), 1, 0);
        for (int i = 0; i < 3; i++)
            step(0, 0, '0, 1, 0);

        // Flush with two kernels in flight
        step(1, 0, rand_kern(), 0, 0);
        step(1, 1, rand_kern(), 0, 0);
        step(0, 0, '0, 0, 1);
        step(1, 1, rand_kern(), 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("clr_next_ch", last_ch, 0);

        // Async reset while the output is stalled
        step(1, 0, rand_kern(), 0, 0);
        step(1, 0, rand_kern(), 0, 0);
        step(0, 0, '0, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_ch", out_ch, 0);
        chk("mid_rst_out_mode", out_mode, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_kernel_out_zero", kernel_out == '0, 1);
        sbq.delete();
        model_ch = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, rand_kern(), 1, 0);
        step(0, 0, '0, 1, 0);
        step(0, 0, '0, 1, 0);
        chk("post_rst_ch", last_ch, 0);

        // 100 random kernels under random backpressure
        n_acc = 0;
        for (int i = 0; i < 3000 && n_acc < 100; i++)
            step($urandom_range(0, 9) < 8, 1'($urandom),
                 rand_kern(), $urandom_range(0, 9) < 6, 0);
        chk("random_accepted", n_acc, 100);
        for (int i = 0; i < 6; i++)
            step(0, 0, '0, 1, 0);
        chk("saw_out_last", seen_last > 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
